uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, optional parity, 1 or 2 stop bits,
// feeding a first-word-fall-through receive FIFO with per-entry error flags.
module uart_rx_fifo #(
    parameter int CLK_PER_BAUD = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLK_PER_BAUD);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;
    localparam logic [CW-1:0] MID_CNT   = CW'((CLK_PER_BAUD - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLK_PER_BAUD - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic                 rx_meta, rxs;
    state_t               state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [3:0]           bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 par_bit, par_bit_next;
    logic                 stop_err, stop_err_next;
    logic                 mid, wrap, perr_calc;
    logic                 push;
    logic [EW-1:0]        push_entry;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic [EW-1:0]        head;
    logic                 empty, full, pop, wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign mid  = (cnt == MID_CNT);
    assign wrap = (cnt == LAST_CNT);

    always_comb begin
        perr_calc = 1'b0;
        if (PARITY == 1)
            perr_calc = ~(^shift ^ par_bit);
        else if (PARITY == 2)
            perr_calc = ^shift ^ par_bit;
    end

    // The final stop bit pushes at its mid-point so a back-to-back start can be caught.
    always_comb begin
        state_next    = state;
        cnt_next      = wrap ? '0 : cnt + 1'b1;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift;
        par_bit_next  = par_bit;
        stop_err_next = stop_err;
        push          = 1'b0;
        push_entry    = {shift, perr_calc, stop_err | ~rxs};
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rxs)
                    state_next = START;
            end
            START: begin
                if (mid && rxs) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (wrap) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (mid)
                    shift_next = {rxs, shift[DATA_BITS-1:1]};
                if (wrap) begin
                    if (bit_cnt == LAST_DATA) begin
                        state_next    = (PARITY != 0) ? PAR : STOP;
                        bit_cnt_next  = '0;
                        stop_err_next = 1'b0;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            PAR: begin
                if (mid)
                    par_bit_next = rxs;
                if (wrap)
                    state_next = STOP;
            end
            STOP: begin
                if (mid && bit_cnt == LAST_STOP) begin
                    push       = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (mid) begin
                    stop_err_next = stop_err | ~rxs;
                end else if (wrap) begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            stop_err <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            bit_cnt  <= bit_cnt_next;
            shift    <= shift_next;
            par_bit  <= par_bit_next;
            stop_err <= stop_err_next;
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = rx_valid && rx_ready;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            overrun <= push && full && !pop;
        end
    end

    assign head       = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign rx_valid   = !empty;
    assign rx_data    = head[EW-1:2];
    assign parity_err = head[1];
    assign frame_err  = head[0];
    assign busy       = (state != IDLE);

endmodule
